calc_secuenciador: RTL
======================

Name: calc_secuenciador

Overview:
- Top-level keypad/operation sequencer for the calculator.
- Turns cursor-position key presses (pos_actual one-hot + BM button) into one-cycle strobes for operand A and B digit registers, latches the selected operation, starts the ALU and waits for its result.
- Produces the 2-bit estado bus consumed by the digit registers and display.

Parameters:
LOCKOUT_CICLOS, 4, cycles after an accepted press during which new BM edges are dropped (debounce)
TIMEOUT_CICLOS, 64, max cycles in CALC waiting for calc_listo before entering ERR

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
BM  in  1  keypad button level (async-clean, already synchronised)
pos_actual  in  26  one-hot cursor position; [15:0] hex digits 0-F, [16..21] ops + - * / & |, [22] CE, [23] backspace, [24] AC, [25] =
calc_listo  in  1  ALU done, single-cycle pulse
calc_error  in  1  ALU error qualifier, valid with calc_listo
estado  out  2  00 ERR, 01 entering A, 10 entering B, 11 CALC/RES
tecla_A  out  1  one-cycle key strobe to operand A register
tecla_B  out  1  one-cycle key strobe to operand B register
C_A  out  1  one-cycle clear of operand A
C_B  out  1  one-cycle clear of operand B
cargar_A  out  1  one-cycle load of result into A (chaining)
op_reg  out  3  latched operation, 0..5 = pos 16..21
calc_inicio  out  1  one-cycle ALU start
error  out  1  high while in ERR

Behaviour:
- Reset (sync): state OPA, op_reg=0, lockout/timeout counters=0, bm_prev=0, all strobes 0, error=0, estado=01.
- Press acceptance: BM=1 while bm_prev=0, lockout counter==0, pos_actual exactly one bit set (popcount 1) → accepted key. Non-one-hot or all-zero → ignored, no lockout started. Accepted key loads lockout = LOCKOUT_CICLOS, decrements to 0 each cycle; edges while nonzero are dropped (not queued).
- All outputs registered: a press sampled at edge t drives its strobe(s) for exactly the cycle following t; a state change takes effect at the same edge.
- OPA (estado 01): digit or backspace → tecla_A. CE → C_A. AC → C_A + C_B, op_reg=0. op key → op_reg=key-16, go OPB. = ignored.
- OPB (estado 10): digit or backspace → tecla_B. CE → C_B. op key → op_reg replaced, stay. = → calc_inicio, go CALC, timeout counter=0. AC → C_A + C_B, op_reg=0, go OPA.
- CALC (estado 11): all keys ignored except AC (abort: C_A+C_B, op_reg=0, go OPA; a later calc_listo is ignored). calc_listo&!calc_error → RES. calc_listo&calc_error → ERR. Timeout counter increments each cycle; reaching TIMEOUT_CICLOS with no calc_listo → ERR. calc_listo and AC accepted in the same cycle: AC wins.
- RES (estado 11): digit → C_A + C_B, go OPA (digit discarded). op key → cargar_A + C_B, op_reg latched, go OPB. AC → C_A + C_B, go OPA. CE, backspace, = ignored.
- ERR (estado 00, error=1): only AC leaves (C_A + C_B, op_reg=0, go OPA). Everything else ignored.
- calc_listo outside CALC: ignored.
- At most one of tecla_A/tecla_B/calc_inicio per cycle. C_A/C_B may pair only as listed.
- Reset mid-operation (any state, any counter value): next cycle fully at reset values. Pending strobes are cancelled.
- BM held high: one accept only; requires a low cycle before the next.

Test Plan:
- Reset, press pos[5] then pos[16] → tecla_A pulse 1 cycle after BM edge, then op_reg=0, estado 01→10, no strobe on op press.
- In OPB press pos[3], then pos[25]; ALU pulses calc_listo 5 cycles after calc_inicio with calc_error=0 → tecla_B pulse, calc_inicio 1 cycle, estado 11, state RES.
- Two BM edges 2 cycles apart with LOCKOUT_CICLOS=4 → only the first produces tecla_A; a third edge 6 cycles after the first is accepted.
- pos_actual=26'h0000003 (two bits) with BM edge → no strobes, no state change. BM held high for 10 cycles → one strobe.
- In CALC, no calc_listo for 64 cycles → estado 00, error=1. Digit press ignored. AC → C_A and C_B same cycle, estado 01.
- From RES press pos[17] → cargar_A and C_B same cycle, op_reg=1, estado 10. Reset asserted during CALC → next cycle estado 01, op_reg=0, all strobes 0.

Source files
------------

// File: rtl/calc_secuenciador_if.sv
// Keypad/ALU handshake bundle between the calculator sequencer and its surroundings.
// master drives keys and ALU status; slave is the sequencer.
interface calc_secuenciador_if;
  logic        BM;
  logic [25:0] pos_actual;
  logic        calc_listo;
  logic        calc_error;
  logic [1:0]  estado;
  logic        tecla_A;
  logic        tecla_B;
  logic        C_A;
  logic        C_B;
  logic        cargar_A;
  logic [2:0]  op_reg;
  logic        calc_inicio;
  logic        error;

  modport master (
    output BM, pos_actual, calc_listo, calc_error,
    input  estado, tecla_A, tecla_B, C_A, C_B, cargar_A, op_reg, calc_inicio, error
  );

  modport slave (
    input  BM, pos_actual, calc_listo, calc_error,
    output estado, tecla_A, tecla_B, C_A, C_B, cargar_A, op_reg, calc_inicio, error
  );
endinterface

// File: rtl/calc_secuenciador.sv
// Calculator key/operation sequencer: debounced key acceptance, operand strobes,
// operation latch, ALU start and result wait with timeout.
//
// state  | meaning
// S_OPA  | entering operand A (estado 01)
// S_OPB  | entering operand B (estado 10)
// S_CALC | ALU running, waiting for calc_listo (estado 11)
// S_RES  | result shown, may chain into a new operation (estado 11)
// S_ERR  | ALU error or timeout, only AC leaves (estado 00)
module calc_secuenciador #(
  parameter int LOCKOUT_CICLOS = 4,
  parameter int TIMEOUT_CICLOS = 64
) (
  input logic                 clock,
  input logic                 reset,
  calc_secuenciador_if.slave  bus
);

  localparam int LW = $clog2(LOCKOUT_CICLOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [2:0] {S_OPA, S_OPB, S_CALC, S_RES, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [LW-1:0]   lock_q, lock_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            bm_prev_q;
  logic            ta_q, ta_d, tb_q, tb_d, ca_q, ca_d, cb_q, cb_d;
  logic            ld_q, ld_d, go_q, go_d;

  logic            one_hot, key_ok;
  logic            k_dig, k_op, k_ce, k_bs, k_ac, k_eq;
  logic [2:0]      op_idx;

  assign one_hot = (bus.pos_actual != '0) &&
                   ((bus.pos_actual & (bus.pos_actual - 26'd1)) == '0);
  assign key_ok  = bus.BM && !bm_prev_q && (lock_q == '0) && one_hot;

  // Key classes are only meaningful when key_ok (exactly one bit set).
  assign k_dig = key_ok && (|bus.pos_actual[15:0]);
  assign k_op  = key_ok && (|bus.pos_actual[21:16]);
  assign k_ce  = key_ok && bus.pos_actual[22];
  assign k_bs  = key_ok && bus.pos_actual[23];
  assign k_ac  = key_ok && bus.pos_actual[24];
  assign k_eq  = key_ok && bus.pos_actual[25];

  always_comb begin
    op_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (bus.pos_actual[16+i]) op_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lock_d  = lock_q;
    tcnt_d  = tcnt_q;
    ta_d    = 1'b0;
    tb_d    = 1'b0;
    ca_d    = 1'b0;
    cb_d    = 1'b0;
    ld_d    = 1'b0;
    go_d    = 1'b0;

    if (lock_q != '0) lock_d = lock_q - 1'b1;
    if (key_ok)       lock_d = LW'(LOCKOUT_CICLOS);

    unique case (state_q)
      S_OPA: begin
        if (k_dig || k_bs) ta_d = 1'b1;
        else if (k_ce) ca_d = 1'b1;
        else if (k_ac) begin
          ca_d = 1'b1;
          cb_d = 1'b1;
          op_d = 3'd0;
        end else if (k_op) begin
          op_d    = op_idx;
          state_d = S_OPB;
        end
      end
      S_OPB: begin
        if (k_dig || k_bs) tb_d = 1'b1;
        else if (k_ce) cb_d = 1'b1;
        else if (k_op) op_d = op_idx;
        else if (k_eq) begin
          go_d    = 1'b1;
          tcnt_d  = '0;
          state_d = S_CALC;
        end else if (k_ac) begin
          ca_d    = 1'b1;
          cb_d    = 1'b1;
          op_d    = 3'd0;
          state_d = S_OPA;
        end
      end
      S_CALC: begin
        // AC aborts and outranks a coincident calc_listo.
        if (k_ac) begin
          ca_d    = 1'b1;
          cb_d    = 1'b1;
          op_d    = 3'd0;
          state_d = S_OPA;
        end else if (bus.calc_listo) begin
          state_d = bus.calc_error ? S_ERR : S_RES;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if ((tcnt_q + 1'b1) == TW'(TIMEOUT_CICLOS)) state_d = S_ERR;
        end
      end
      S_RES: begin
        if (k_dig || k_ac) begin
          ca_d    = 1'b1;
          cb_d    = 1'b1;
          state_d = S_OPA;
        end else if (k_op) begin
          ld_d    = 1'b1;
          cb_d    = 1'b1;
          op_d    = op_idx;
          state_d = S_OPB;
        end
      end
      S_ERR: begin
        if (k_ac) begin
          ca_d    = 1'b1;
          cb_d    = 1'b1;
          op_d    = 3'd0;
          state_d = S_OPA;
        end
      end
      default: state_d = S_OPA;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_OPA;
      op_q      <= 3'd0;
      lock_q    <= '0;
      tcnt_q    <= '0;
      bm_prev_q <= 1'b0;
      ta_q      <= 1'b0;
      tb_q      <= 1'b0;
      ca_q      <= 1'b0;
      cb_q      <= 1'b0;
      ld_q      <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      lock_q    <= lock_d;
      tcnt_q    <= tcnt_d;
      bm_prev_q <= bus.BM;
      ta_q      <= ta_d;
      tb_q      <= tb_d;
      ca_q      <= ca_d;
      cb_q      <= cb_d;
      ld_q      <= ld_d;
      go_q      <= go_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_OPA:         bus.estado = 2'b01;
      S_OPB:         bus.estado = 2'b10;
      S_CALC, S_RES: bus.estado = 2'b11;
      default:       bus.estado = 2'b00;
    endcase
  end

  assign bus.error       = (state_q == S_ERR);
  assign bus.op_reg      = op_q;
  assign bus.tecla_A     = ta_q;
  assign bus.tecla_B     = tb_q;
  assign bus.C_A         = ca_q;
  assign bus.C_B         = cb_q;
  assign bus.cargar_A    = ld_q;
  assign bus.calc_inicio = go_q;

endmodule
